// File: rtl/background_rom_arbiter.sv
// background_rom_arbiter: shares the background ROM read port between the
// VGA pixel fetch and NUM_REQ game-logic probes (display first in active video).
// Ports:
//   vga_clk, reset            pixel clock, async active-high reset
//   DrawX, DrawY, blank       display coordinates, 1 = active video
//   req_valid/req_x/req_y     probe requests (packed 10-bit coordinates)
//   req_ready                 one-hot grant
//   resp_valid/index/oob      probe response, two cycles after accept
//   rom_address, rom_q        ROM port (rom_q lags address by one cycle)
//   pixel_index, pixel_valid  display result, two cycles after sample
//   steal_count               saturating count of stolen display cycles
module background_rom_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int MAX_WAIT = 256
) (
    input  logic                    vga_clk,
    input  logic                    reset,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic                    blank,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [10*NUM_REQ-1:0]   req_x,
    input  logic [10*NUM_REQ-1:0]   req_y,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [3:0]              resp_index,
    output logic                    resp_oob,
    output logic [18:0]             rom_address,
    input  logic [3:0]              rom_q,
    output logic [3:0]              pixel_index,
    output logic                    pixel_valid,
    output logic [15:0]             steal_count
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        OWN_DISP,
        OWN_STEAL,
        OWN_REQ
    } owner_e;

    logic [PW-1:0]      r_ptr;
    logic [15:0]        r_wait [NUM_REQ];
    logic [NUM_REQ-1:0] r_s1_valid;
    logic               r_s1_oob;
    owner_e             r_s1_owner;
    logic               r_s1_blank;

    logic [9:0]         w_x [NUM_REQ];
    logic [9:0]         w_y [NUM_REQ];
    logic [18:0]        w_addr [NUM_REQ];
    logic [NUM_REQ-1:0] w_inrange;
    logic [NUM_REQ-1:0] w_starved;
    logic [NUM_REQ-1:0] w_oob_pend;
    logic [NUM_REQ-1:0] w_cand;
    logic [18:0]        w_disp_addr;
    owner_e             w_owner;
    logic               w_found;
    logic [PW-1:0]      w_win;
    logic               w_use_rom;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        assign w_x[i]        = req_x[10*i +: 10];
        assign w_y[i]        = req_y[10*i +: 10];
        assign w_inrange[i]  = (w_x[i] < 10'd640) && (w_y[i] < 10'd480);
        assign w_addr[i]     = 19'(w_y[i]) * 19'd640 + 19'(w_x[i]);
        assign w_oob_pend[i] = req_valid[i] && !w_inrange[i];
        // Only in-range ports can starve: OOB ports never need the ROM.
        assign w_starved[i]  = (MAX_WAIT != 0) && req_valid[i] &&
                               w_inrange[i] &&
                               (32'(r_wait[i]) >= 32'(MAX_WAIT));
    end

    assign w_disp_addr = 19'(DrawY) * 19'd640 + 19'(DrawX);

    // Cycle owner and the set of ports allowed to compete this cycle.
    always_comb begin
        w_owner = OWN_REQ;
        w_cand  = req_valid;
        if (blank) begin
            if (|w_starved) begin
                w_owner = OWN_STEAL;
                w_cand  = w_starved;
            end else begin
                w_owner = OWN_DISP;
                w_cand  = w_oob_pend;
            end
        end
    end

    // Round-robin search starting just after the last granted port.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && w_cand[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_found && (w_win == PW'(i));
        end
    end

    assign w_use_rom = w_found && w_inrange[w_win];

    always_comb begin
        rom_address = w_disp_addr;
        if (reset) begin
            rom_address = '0;
        end else if (w_use_rom) begin
            rom_address = w_addr[w_win];
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= PW'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wait[i] <= '0;
            end
            r_s1_valid  <= '0;
            r_s1_oob    <= 1'b0;
            r_s1_owner  <= OWN_REQ;
            r_s1_blank  <= 1'b0;
            resp_valid  <= '0;
            resp_index  <= '0;
            resp_oob    <= 1'b0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            steal_count <= '0;
        end else begin
            if (w_found) begin
                r_ptr <= w_win;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || req_ready[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != 16'hFFFF) begin
                    r_wait[i] <= r_wait[i] + 16'd1;
                end
            end
            if (w_owner == OWN_STEAL && steal_count != 16'hFFFF) begin
                steal_count <= steal_count + 16'd1;
            end

            // Stage 1: who owns the ROM data arriving next cycle.
            r_s1_valid <= req_ready;
            r_s1_oob   <= w_found && !w_inrange[w_win];
            r_s1_owner <= w_owner;
            r_s1_blank <= blank;

            // Stage 2: route rom_q; a stolen slot keeps the old pixel.
            resp_valid  <= r_s1_valid;
            resp_oob    <= (|r_s1_valid) && r_s1_oob;
            resp_index  <= ((|r_s1_valid) && !r_s1_oob) ? rom_q : 4'd0;
            pixel_valid <= r_s1_blank;
            if (r_s1_owner == OWN_DISP) begin
                pixel_index <= rom_q;
            end
        end
    end

endmodule
